fetch_controller: RTL
=====================

Name: fetch_controller

Overview:
- Sequences the CPU's combinational instruction memory: holds the program counter and drives the 8-bit fetch address.
- Captures the returned 32-bit instruction into a registered output slot and hands it to decode with a valid/ready handshake.
- Sits between instruction memory and the decode/execute stage.
- Handles start/halt control and jump redirects from execute.

Parameters:
- ADDR_W, 8, instruction-memory address width; PC wraps modulo 2^ADDR_W.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC value after reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; leave IDLE and begin fetching at the current PC.
- halt_req  in  1  pulse; stop fetching and drain to IDLE.
- jump_valid  in  1  redirect request from execute.
- jump_target  in  ADDR_W  redirect address.
- imem_address  out  ADDR_W  address to instruction memory; always equals pc.
- imem_instruction  in  INSTR_W  same-cycle combinational data from instruction memory.
- instr_data  out  INSTR_W  registered instruction to decode.
- instr_pc  out  ADDR_W  address the instruction in instr_data was fetched from.
- instr_valid  out  1  output slot holds a valid instruction.
- instr_ready  in  1  decode accepts the instruction this cycle.
- pc  out  ADDR_W  current fetch pointer.
- running  out  1  high in state RUN.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - pc = RESET_PC; state = IDLE.
  - instr_valid = 0; instr_data = 0 (NOP); instr_pc = 0; running = 0.
- Handshake:
  - A transfer occurs on a cycle where instr_valid && instr_ready.
  - While instr_valid && !instr_ready, instr_data and instr_pc hold stable.
  - The slot is free when !instr_valid || instr_ready.
- IDLE:
  - No fetch; pc holds.
  - Any held output slot drains normally through the handshake.
  - start -> RUN.
- RUN: on each edge where the slot is free:
  - instr_data <= imem_instruction; instr_pc <= pc; instr_valid <= 1; pc <= pc+1.
  - Throughput is one instruction per cycle.
  - If the slot is not free, pc holds (stall).
- Latency:
  - start sampled at edge k -> first instruction valid after edge k+1.
- Jump (highest priority, accepted only in RUN/DRAIN):
  - At the sampling edge: pc <= jump_target; instr_valid <= 0. This flushes the slot even if stalled; the flushed instruction is never transferred.
  - Instruction at jump_target becomes valid after the next edge. Exactly one bubble.
  - In DRAIN, a jump still updates pc and flushes, then goes to IDLE.
  - jump_valid in IDLE is ignored.
- DRAIN (entered from RUN on halt_req):
  - No new fetch.
  - When the slot is empty or being accepted this cycle -> IDLE; otherwise hold.
  - pc points at the next unfetched address, so start resumes there.
- Simultaneous events, same cycle:
  - jump + halt_req: take the jump, then go to DRAIN.
  - start + halt_req in IDLE: halt wins, stay IDLE.
  - start in RUN: ignored.
- Wrap-around: pc 2^ADDR_W-1 increments to 0, no flag.
- running = (state == RUN).
- States: IDLE, RUN, DRAIN. Encoding comes from the shared definitions.

Optional Feature:
- Macro: FETCH_BREAKPOINT_EN.
- With the macro, extra ports:
  - bp_enable in 1.
  - bp_address in ADDR_W.
  - bp_hit out 1, reset 0.
- Breakpoint behaviour: in RUN, if bp_enable && pc == bp_address when a fetch would occur:
  - No fetch; pc holds at bp_address.
  - State -> DRAIN; bp_hit <= 1 (sticky).
- A jump on the same cycle takes priority and suppresses the hit.
- start clears bp_hit, and the first fetch after start ignores the breakpoint so the breakpointed instruction is fetched.
- Without the macro: ports absent, no comparison logic.

Decomposition:
- Shared CPU definitions header holds:
  - State encodings FETCH_IDLE/FETCH_RUN/FETCH_DRAIN (2 bits).
  - NOP constant 32'd0.
  - Address width constant.
- One natural sub-module: fetch_output_slot, the valid/data/pc register with load, hold and flush controls.

Test Plan:
- Reset then start, instr_ready=1, memory returning {addr+1}: instr_pc 0,1,2,... on consecutive cycles, first valid one cycle after start, no gaps.
- Backpressure: instr_ready=0 for 3 cycles while holding instr_pc=4: instr_data/instr_pc stable, pc stays 5; on ready=1, addr 5 follows next cycle.
- Jump: jump_valid with jump_target=0 while slot holds instr_pc=10, ready=0: slot flushed (no transfer of 10), one bubble, next valid has instr_pc=0.
- halt_req with ready=0: state DRAIN until transfer, then IDLE; running=0; a later start resumes at the saved pc, no skipped or duplicated address.
- Wrap and reset mid-operation: run from pc=254: instr_pc 254,255,0. Assert reset_n=0 mid-stream: instr_valid drops immediately, pc=RESET_PC.
- With FETCH_BREAKPOINT_EN: bp_address=3, enabled: instr_pc 0,1,2 delivered, then bp_hit=1 and IDLE with pc=3. Next start clears bp_hit and fetches addr 3.

Source files
------------

// File: rtl/fetch_controller_pkg.sv
// -----------------------------------------------------------------------------
// fetch_controller_pkg
// Shared CPU definitions for the instruction-fetch front end:
//   - fetch FSM state encodings (FETCH_IDLE / FETCH_RUN / FETCH_DRAIN, 2 bits)
//   - NOP instruction constant (all zeros)
//   - default instruction-memory address width and instruction width
// No ports; imported by fetch_controller and fetch_output_slot.
// -----------------------------------------------------------------------------
package fetch_controller_pkg;

    localparam int FETCH_ADDR_W  = 8;
    localparam int FETCH_INSTR_W = 32;

    // Value presented to decode when the output slot holds nothing.
    localparam logic [31:0] FETCH_NOP = 32'd0;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_output_slot.sv
// -----------------------------------------------------------------------------
// fetch_output_slot
// Single-entry registered slot between instruction fetch and decode.
// Holds {valid, instruction, fetch address}. Controls, in priority order:
//   flush_i : drop the held instruction (it is never transferred)
//   load_i  : capture data_i / pc_i and mark valid
//   otherwise the entry empties on an accepted transfer (valid_o && ready_i)
//   and holds stable while valid_o && !ready_i.
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   load_i, flush_i, ready_i  slot controls / downstream ready
//   data_i, pc_i              instruction and address to capture
//   valid_o, data_o, pc_o     registered slot contents
// -----------------------------------------------------------------------------
module fetch_output_slot
    import fetch_controller_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic               ready_i,
    input  logic [INSTR_W-1:0] data_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] data_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] data_q;
    logic [ADDR_W-1:0]  pc_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= INSTR_W'(FETCH_NOP);
            pc_q    <= '0;
        end else if (flush_i) begin
            // Data and address are left as-is; only valid matters downstream.
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            pc_q    <= pc_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
// Instruction-fetch sequencer for a combinational instruction memory. Holds
// the program counter, drives the fetch address, and hands each returned
// instruction to decode through a registered valid/ready output slot.
// Handles start/halt control and jump redirects from execute.
//
// Ports:
//   clock, reset_n        clock (rising edge), asynchronous active-low reset;
//                         release is expected to be synchronised upstream
//   start, halt_req       control pulses
//   jump_valid/target     redirect from execute (ignored in IDLE)
//   imem_address          fetch address (always equals pc)
//   imem_instruction      same-cycle instruction-memory data
//   instr_data/pc/valid   output slot towards decode; instr_ready from decode
//   pc                    current fetch pointer
//   running               high while in RUN
//
// Build option FETCH_BREAKPOINT_EN adds bp_enable, bp_address and bp_hit:
// a fetch from bp_address in RUN is suppressed, the FSM drains to IDLE with
// pc left at bp_address, and bp_hit is set until the next start.
// -----------------------------------------------------------------------------
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                INSTR_W  = FETCH_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               halt_req,
    input  logic               jump_valid,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic [ADDR_W-1:0]  imem_address,
    input  logic [INSTR_W-1:0] imem_instruction,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               running
`ifdef FETCH_BREAKPOINT_EN
    ,
    input  logic               bp_enable,
    input  logic [ADDR_W-1:0]  bp_address,
    output logic               bp_hit
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              running_q;
    logic              slot_free;
    logic              slot_load;
    logic              slot_flush;

`ifdef FETCH_BREAKPOINT_EN
    logic bp_hit_q, bp_hit_d;
    // Set by start so the instruction sitting at the breakpoint is fetched
    // once on resume instead of re-triggering immediately.
    logic bp_skip_q, bp_skip_d;
`endif

    // Slot can take a new instruction if empty or being drained this cycle.
    assign slot_free = !instr_valid || instr_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        slot_load  = 1'b0;
        slot_flush = 1'b0;
`ifdef FETCH_BREAKPOINT_EN
        bp_hit_d   = bp_hit_q;
        bp_skip_d  = bp_skip_q;
`endif
        case (state_q)
            FETCH_IDLE: begin
                // halt_req wins over a simultaneous start.
                if (start && !halt_req) begin
                    state_d = FETCH_RUN;
`ifdef FETCH_BREAKPOINT_EN
                    bp_hit_d  = 1'b0;
                    bp_skip_d = 1'b1;
`endif
                end
            end
            FETCH_RUN: begin
                if (jump_valid) begin
                    // Redirect flushes the slot even under backpressure.
                    pc_d       = jump_target;
                    slot_flush = 1'b1;
                    state_d    = halt_req ? FETCH_DRAIN : FETCH_RUN;
                end else if (halt_req) begin
                    state_d = FETCH_DRAIN;
                end else if (slot_free) begin
`ifdef FETCH_BREAKPOINT_EN
                    if (bp_enable && !bp_skip_q && (pc_q == bp_address)) begin
                        state_d  = FETCH_DRAIN;
                        bp_hit_d = 1'b1;
                    end else begin
                        slot_load = 1'b1;
                        pc_d      = pc_q + ADDR_W'(1);
                        bp_skip_d = 1'b0;
                    end
`else
                    slot_load = 1'b1;
                    pc_d      = pc_q + ADDR_W'(1);
`endif
                end
            end
            FETCH_DRAIN: begin
                if (jump_valid) begin
                    pc_d       = jump_target;
                    slot_flush = 1'b1;
                    state_d    = FETCH_IDLE;
                end else if (slot_free) begin
                    state_d = FETCH_IDLE;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FETCH_IDLE;
            pc_q      <= RESET_PC;
            running_q <= 1'b0;
`ifdef FETCH_BREAKPOINT_EN
            bp_hit_q  <= 1'b0;
            bp_skip_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= (state_d == FETCH_RUN);
`ifdef FETCH_BREAKPOINT_EN
            bp_hit_q  <= bp_hit_d;
            bp_skip_q <= bp_skip_d;
`endif
        end
    end

    fetch_output_slot #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_slot (
        .clock   (clock),
        .reset_n (reset_n),
        .load_i  (slot_load),
        .flush_i (slot_flush),
        .ready_i (instr_ready),
        .data_i  (imem_instruction),
        .pc_i    (pc_q),
        .valid_o (instr_valid),
        .data_o  (instr_data),
        .pc_o    (instr_pc)
    );

    assign imem_address = pc_q;
    assign pc           = pc_q;
    assign running      = running_q;
`ifdef FETCH_BREAKPOINT_EN
    assign bp_hit       = bp_hit_q;
`endif

endmodule
